// File: rtl/conv_pkg.sv
// Shared convolutional-code definitions: default code parameters, generator
// extraction, encoder FSM states and trellis-table entry indexing.
package conv_pkg;

  localparam int R_DEF = 2;
  localparam int K_DEF = 3;
  localparam logic [R_DEF*K_DEF-1:0] G_DEF = 6'b111_101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // Generator j lives at G[k*(r-j)-1 -: k]; returned right-aligned.
  function automatic logic [31:0] gen_extract(input logic [63:0] g, input int r,
                                              input int k, input int j);
    logic [63:0] mask;
    logic [63:0] sh;
    mask = (64'd1 << k) - 64'd1;
    sh   = (g >> (k * (r - 1 - j))) & mask;
    return sh[31:0];
  endfunction

  // Trellis table entry for shift-register state s and input bit b.
  function automatic int entry_idx(input int s, input int b);
    return s * 2 + b;
  endfunction

endpackage

// File: rtl/conv_parity.sv
// Combinational parity generator: one r-bit symbol from the window w = {u, sr}
// using the generator set G (bit K-1 of each generator taps the current input).
module conv_parity
  import conv_pkg::*;
#(
  parameter int r = R_DEF,
  parameter int K = K_DEF,
  parameter logic [r*K-1:0] G = G_DEF
) (
  input  logic [K-1:0] w,
  output logic [r-1:0] sym
);

  for (genvar j = 0; j < r; j++) begin : g_tap
    localparam logic [31:0]  GEN32 = gen_extract(64'(G), r, K, j);
    localparam logic [K-1:0] GEN   = GEN32[K-1:0];
    assign sym[r-1-j] = ^(w & GEN);
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/r feed-forward convolutional encoder with a valid/ready symbol port,
// packed code word and trellis table. Optional tail flush: CONV_ENC_TAIL_EN.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int r      = R_DEF,
  parameter int K      = K_DEF,
  parameter int lenout = 5,
  parameter logic [r*K-1:0] G = G_DEF,
`ifdef CONV_ENC_TAIL_EN
  localparam int TAIL  = K - 1,
`else
  localparam int TAIL  = 0,
`endif
  localparam int lenin  = (lenout + TAIL) * r,
  localparam int NSTATE = 1 << (K - 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [lenout-1:0]       msgin,
  input  logic                    sym_ready,
  output logic                    sym_valid,
  output logic [r-1:0]            sym_out,
  output logic [lenin-1:0]        codeout,
  output logic [NSTATE*2*r-1:0]   states,
  output logic                    busy,
  output logic                    finish,
  output conv_state_e             dbg_state
);

  // Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready;
  // sym_valid never depends on sym_ready and sym_out is held until it transfers.

  localparam int NSYM = lenout + TAIL;
  localparam int CW   = $clog2(NSYM + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MSG  = CW'(lenout);
  localparam logic [CW-1:0] CNT_LAST = CW'(NSYM - 1);

  conv_state_e          state_q, state_d;
  logic [lenout-1:0]    msg_q, msg_d;
  logic [K-2:0]         sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [lenin-r-1:0]   acc_q, acc_d;
  logic [lenin-1:0]     acc_next;
  logic [lenin-1:0]     codeout_q, codeout_d;
  logic                 finish_q, finish_d;
  logic                 u;
  logic [K-1:0]         w;
  logic [r-1:0]         sym_w;
  logic                 hs;

  // Past the message the input is forced to zero, which is the tail flush.
  assign u = (cnt_q < CNT_MSG) ? msg_q[lenout-1] : 1'b0;
  assign w = {u, sr_q};

  conv_parity #(.r(r), .K(K), .G(G)) u_parity (
    .w   (w),
    .sym (sym_w)
  );

  assign sym_valid = (state_q == ST_ENC);
  assign sym_out   = sym_valid ? sym_w : '0;
  assign hs        = sym_valid & sym_ready;
  assign acc_next  = {acc_q, sym_w};

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    codeout_d = codeout_q;
    finish_d  = finish_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_d    = msgin;
          sr_d     = '0;
          cnt_d    = '0;
          acc_d    = '0;
          finish_d = 1'b0;
          state_d  = ST_ENC;
        end
      end
      ST_ENC: begin
        if (hs) begin
          acc_d = acc_next[lenin-r-1:0];
          // New bit enters at the top, oldest drops out of sr[0].
          sr_d  = w[K-1:1];
          msg_d = {msg_q[lenout-2:0], 1'b0};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            codeout_d = acc_next;
            finish_d  = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      msg_q     <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      codeout_q <= '0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      codeout_q <= codeout_d;
      finish_q  <= finish_d;
    end
  end

  assign codeout   = codeout_q;
  assign finish    = finish_q;
  assign busy      = (state_q == ST_ENC);
  assign dbg_state = state_q;

  // Expected-parity table for the decoder: entry {b, s} at [e*r +: r].
  for (genvar s = 0; s < NSTATE; s++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int E = entry_idx(s, b);
      localparam logic [K-1:0] W_E = K'((b << (K - 1)) | s);
      conv_parity #(.r(r), .K(K), .G(G)) u_tbl (
        .w   (W_E),
        .sym (states[E*r +: r])
      );
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: vector table, hand-written corner
// sequences and randomized messages against a convolution-sum reference model.
`timescale 1ns/1ps
module tb_conv_encoder;
  import conv_pkg::*;

  localparam int R      = 2;
  localparam int K      = 3;
  localparam int LENOUT = 5;
`ifdef CONV_ENC_TAIL_EN
  localparam int TAIL   = K - 1;
`else
  localparam int TAIL   = 0;
`endif
  localparam int NSYM   = LENOUT + TAIL;
  localparam int LENIN  = NSYM * R;
  localparam int STW    = (1 << (K - 1)) * 2 * R;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LENOUT-1:0] msgin;
  logic              sym_ready;
  logic              sym_valid;
  logic [R-1:0]      sym_out;
  logic [LENIN-1:0]  codeout;
  logic [STW-1:0]    states;
  logic              busy;
  logic              finish;
  conv_state_e       dbg_state;

  always #5 clk = ~clk;

  conv_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .msgin     (msgin),
    .sym_ready (sym_ready),
    .sym_valid (sym_valid),
    .sym_out   (sym_out),
    .codeout   (codeout),
    .states    (states),
    .busy      (busy),
    .finish    (finish),
    .dbg_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int               checks   = 0;
  int               failures = 0;
  logic [R-1:0]     exp_q[$];
  logic [LENIN-1:0] last_code;
  logic [K-1:0]     gen_tab [R] = '{3'b111, 3'b101};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: each parity bit is the XOR of generator-tapped input bits
  // over the last K inputs (zero before the message starts).
  task automatic model_encode(input logic [LENOUT-1:0] msg, output logic [LENIN-1:0] code);
    int           bits [NSYM];
    logic [R-1:0] sym;
    logic         p;
    code = '0;
    for (int i = 0; i < NSYM; i++) bits[i] = (i < LENOUT) ? int'(msg[LENOUT-1-i]) : 0;
    for (int i = 0; i < NSYM; i++) begin
      for (int j = 0; j < R; j++) begin
        p = 1'b0;
        for (int k = 0; k < K; k++)
          if (i - k >= 0 && bits[i-k] == 1 && gen_tab[j][K-1-k] == 1'b1) p = ~p;
        sym[R-1-j] = p;
      end
      exp_q.push_back(sym);
      code = {code[LENIN-R-1:0], sym};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [LENOUT-1:0] m);
    @(negedge clk);
    start = 1'b1;
    msgin = m;
    @(negedge clk);
    start = 1'b0;
    msgin = LENOUT'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_after_start", 32'(sym_valid), 32'd1);
    check("finish_clear_on_start", 32'(finish), 32'd0);
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready.
  task automatic run_symbols(input int mode, input int n_hs, input bit inject,
                             input logic [LENOUT-1:0] inj_msg);
    int           hs = 0;
    int           cyc = 0;
    bit           stalled = 1'b0;
    bit           rdy;
    logic [R-1:0] held;
    logic [R-1:0] exp_sym;
    while (hs < n_hs && cyc < 200) begin
      check("valid_in_enc", 32'(sym_valid), 32'd1);
      check("finish_low_in_enc", 32'(finish), 32'd0);
      check("codeout_hold", 32'(codeout), 32'(last_code));
      if (stalled) check("sym_stall_stable", 32'(sym_out), 32'(held));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sym_ready = rdy;
      start     = inject && (hs == 2);
      msgin     = inj_msg;
      if (rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL exp_q_underflow: got symbol 0x%0h required none", sym_out);
        end else begin
          exp_sym = exp_q.pop_front();
          check("sym_out", 32'(sym_out), 32'(exp_sym));
        end
        hs++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = sym_out;
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    sym_ready = 1'b0;
    if (hs < n_hs) check("handshake_timeout", 32'(hs), 32'(n_hs));
  endtask

  task automatic check_done(input logic [LENIN-1:0] exp_code, input bit done_start);
    check("finish_after_last", 32'(finish), 32'd1);
    check("codeout", 32'(codeout), 32'(exp_code));
    check("valid_drop", 32'(sym_valid), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    last_code = exp_code;
    if (done_start) begin
      start = 1'b1;
      msgin = LENOUT'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("finish_hold", 32'(finish), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("codeout_hold_idle", 32'(codeout), 32'(exp_code));
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [LENOUT-1:0] msg;
    logic [LENIN-1:0]  code;
  } vec_t;

  vec_t             vecs [4];
  logic [LENIN-1:0] mcode;
  logic [LENOUT-1:0] rmsg;

  initial begin
`ifdef CONV_ENC_TAIL_EN
    vecs[0] = '{msg: 5'b10110, code: 14'b11100001011100};
    vecs[1] = '{msg: 5'b00001, code: 14'b00000000111011};
    vecs[2] = '{msg: 5'b00000, code: 14'b00000000000000};
    vecs[3] = '{msg: 5'b11111, code: 14'b11011010100111};
`else
    vecs[0] = '{msg: 5'b10110, code: 10'b1110000101};
    vecs[1] = '{msg: 5'b00001, code: 10'b0000000011};
    vecs[2] = '{msg: 5'b00000, code: 10'b0000000000};
    vecs[3] = '{msg: 5'b11111, code: 10'b1101101010};
`endif
    rst       = 1'b0;
    start     = 1'b0;
    sym_ready = 1'b0;
    msgin     = '0;
    last_code = '0;
    repeat (3) @(negedge clk);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_sym_out", 32'(sym_out), 32'd0);
    check("rst_codeout", 32'(codeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("states_table", 32'(states), 32'h963C);
    rst = 1'b1;

    // Vector table, ready held high.
    for (int i = 0; i < 4; i++) begin
      model_encode(vecs[i].msg, mcode);
      do_start(vecs[i].msg);
      run_symbols(0, NSYM, 1'b0, '0);
      check_done(vecs[i].code, 1'b0);
    end

    // Ready toggling every cycle.
    model_encode(5'b10110, mcode);
    do_start(5'b10110);
    run_symbols(1, NSYM, 1'b0, '0);
    check_done(vecs[0].code, 1'b0);

    // Start during ENC and during DONE ignored, then a fresh start accepted.
    model_encode(5'b10110, mcode);
    do_start(5'b10110);
    run_symbols(1, NSYM, 1'b1, 5'b01001);
    check_done(vecs[0].code, 1'b1);
    model_encode(5'b11111, mcode);
    do_start(5'b11111);
    run_symbols(0, NSYM, 1'b0, '0);
    check_done(vecs[3].code, 1'b0);

    // Reset after the third handshake aborts the word.
    model_encode(5'b10110, mcode);
    do_start(5'b10110);
    run_symbols(0, 3, 1'b0, '0);
    rst = 1'b0;
    #1;
    check("abort_sym_valid", 32'(sym_valid), 32'd0);
    check("abort_sym_out", 32'(sym_out), 32'd0);
    check("abort_codeout", 32'(codeout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_finish", 32'(finish), 32'd0);
    check("abort_states", 32'(states), 32'h963C);
    exp_q.delete();
    last_code = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_encode(5'b00001, mcode);
    do_start(5'b00001);
    run_symbols(0, NSYM, 1'b0, '0);
    check_done(vecs[1].code, 1'b0);

    // Randomized messages with random backpressure.
    for (int n = 0; n < 20; n++) begin
      rmsg = LENOUT'($urandom);
      model_encode(rmsg, mcode);
      do_start(rmsg);
      run_symbols(2, NSYM, 1'b0, '0);
      check_done(mcode, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/r feed-forward convolutional encoder, the transmit-side counterpart of the Lab 6 Viterbi decoder. It accepts a lenout-bit message word, shifts it MSB-first through a (K-1)-bit shift register, and emits one r-bit parity symbol per message bit. Symbols go out on a valid/ready serial port and are also packed into a lenin-bit code word whose layout the decoder's `codein` input accepts directly. It also drives the per-state expected-parity trellis table the decoder takes on its `states` input.

## Interface
- `r`, 2: parity bits per symbol.
- `K`, 3: constraint length.
- `lenout`, 5: message length.
- `G`, 6'b111_101: generators, r*K bits. Generator j = G[K*(r-j)-1 -: K]; bit K-1 taps the current input.
- `TAIL`, derived: K-1 when the tail feature is compiled in, else 0.
- `lenin`, derived: (lenout+TAIL)*r.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `msgin`  in  lenout: message; captured on accepted start.
- `sym_ready`  in  1: downstream accepts symbol.
- `sym_valid`  out  1: symbol present.
- `sym_out`  out  r: current parity symbol.
- `codeout`  out  lenin: packed code word; first symbol in the MS r bits.
- `states`  out  2^(K-1)*2*r: trellis table, combinational from parameters only.
- `busy`  out  1: high in ENC.
- `finish`  out  1: level; result valid.

## Operation
- FSM states IDLE, ENC, DONE.
- IDLE + start: capture msgin into msg_reg, clear sr, clear cnt, clear acc, go to ENC.
- ENC:
  - u = msg_reg[lenout-1] while cnt < lenout, else 0 (tail).
  - w = {u, sr}; sr[K-2] is the previous bit, sr[0] the oldest.
  - sym_out[r-1-j] = ^(w & generator j).
  - On sym_valid && sym_ready: acc = {acc, sym_out}; sr = {u, sr[K-2:1]}; msg_reg shifts left; cnt++.
  - On the handshake with cnt == lenout+TAIL-1: codeout <= next acc, finish <= 1, go to DONE.
- DONE: go to IDLE next cycle; finish stays high.
- finish clears on the next accepted start.
- codeout holds the previous result until the new word completes.
- start in ENC or DONE is ignored; no queuing.
- sym_ready low stalls everything. sym_out stays stable while valid and not ready.
- states table: entry index e = s*2+b, where s is the state value (sr) and b the input bit. The entry holds the parity for w = {b, s} at [e*r +: r].
- Widths: cnt is $clog2(lenout+TAIL+1) bits; parity is XOR-reduction only, no arithmetic.

## Timing
- Reset values (async on rst low):
  - sym_valid=0, sym_out=0, codeout=0, busy=0, finish=0.
  - FSM=IDLE, sr=0, cnt=0.
- Start sampled at edge E0. sym_valid and busy rise after E0.
- With sym_ready held high, handshakes occur at E1..E(lenout+TAIL). finish and codeout update at that last edge, so code-word latency is lenout+TAIL+1 cycles.
- sym_valid drops in the cycle after the last handshake; DONE lasts one cycle.
- Reset mid-ENC: aborts, nothing partial reaches codeout.

## Configuration
- `CONV_ENC_TAIL_EN` defined: TAIL=K-1. K-1 zero bits are appended to return the trellis to state 0, and lenin grows to (lenout+K-1)*r.
- Not defined: no tail. lenin = lenout*r (10 at defaults), matching the current decoder.

## Structure
- Shared package `conv_pkg`:
  - default r, K, G
  - generator-extract function
  - FSM state typedef
  - trellis-entry index function
- The decoder's bmu table uses the same package.
- One sub-module, `conv_parity`: combinational, takes w and G, produces the r-bit symbol. It is instantiated once for the datapath and 2^(K-1)*2 times in a generate loop for `states`.

## Test plan
- Defaults, no tail, msgin=5'b10110, sym_ready=1: symbols 11,10,00,01,01 on E1..E5; codeout=10'b1110000101; finish high after E5.
- `states` at defaults -> 16'h963C; compare against the decoder's expected table.
- Same message with sym_ready toggling 1/0 each cycle: same symbol sequence; sym_out stable during stalls; finish after the 5th handshake.
- `CONV_ENC_TAIL_EN`, msgin=5'b10110: 7 symbols ending 11,00; codeout=14'b11100001011100.
- start pulsed during ENC with a different msgin: ignored; result unchanged; back-to-back start in IDLE after DONE accepted, finish clears.
- rst low after the 3rd handshake: all outputs 0 immediately; new start then encodes msgin=5'b00001 -> codeout=10'b0000000011.
